thunderbird_lights: RTL

Turn-signal sequencer producing the 6-bit `LEDS` vector consumed by the VGA pixel generator, which draws three left lamps and three right lamps. It synchronises the left/right/hazard switch inputs, divides the system clock into a slow step tick, and runs a Moore state machine that sweeps the lamps outward or flashes all six. It sits directly upstream of the pixel generator, with `LEDS` wired straight to that block's `LEDS` input.

---
 rtl/tbird_pkg.sv | 49 ++++
 rtl/tick_divider.sv | 39 +++
 rtl/thunderbird_lights.sv | 93 +++++++++
 3 files changed

// File: rtl/tbird_pkg.sv
// Shared types and constants for the thunderbird turn-signal sequencer.
package tbird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_LR3  = 3'd7
  } tb_state_t;

  // Bit positions of each lamp inside the LEDS vector.
  localparam int IDX_R3 = 0;
  localparam int IDX_R2 = 1;
  localparam int IDX_R1 = 2;
  localparam int IDX_L1 = 3;
  localparam int IDX_L2 = 4;
  localparam int IDX_L3 = 5;

  localparam logic [5:0] LED_IDLE = 6'b000000;
  localparam logic [5:0] LED_L1   = 6'b000001 << IDX_L1;
  localparam logic [5:0] LED_L2   = LED_L1 | (6'b000001 << IDX_L2);
  localparam logic [5:0] LED_L3   = LED_L2 | (6'b000001 << IDX_L3);
  localparam logic [5:0] LED_R1   = 6'b000001 << IDX_R1;
  localparam logic [5:0] LED_R2   = LED_R1 | (6'b000001 << IDX_R2);
  localparam logic [5:0] LED_R3   = LED_R2 | (6'b000001 << IDX_R3);
  localparam logic [5:0] LED_LR3  = LED_L3 | LED_R3;

  // Lamp pattern shown while the FSM sits in a given state.
  function automatic logic [5:0] led_pattern(input tb_state_t st);
    logic [5:0] pat;
    pat = LED_IDLE;
    case (st)
      ST_L1:   pat = LED_L1;
      ST_L2:   pat = LED_L2;
      ST_L3:   pat = LED_L3;
      ST_R1:   pat = LED_R1;
      ST_R2:   pat = LED_R2;
      ST_R3:   pat = LED_R3;
      ST_LR3:  pat = LED_LR3;
      default: pat = LED_IDLE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: registered one-cycle strobe every DIV cycles.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Wrap the counter at DIV-1 and strobe in the following cycle.
  always_comb begin
    cnt_d  = cnt_q + W'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/thunderbird_lights.sv
// Turn-signal sequencer: switch synchronisers, step divider and lamp FSM.
module thunderbird_lights
  import tbird_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int STEP_HZ  = 4,
  parameter int TICK_DIV = CLK_HZ / STEP_HZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [5:0] LEDS,
  output logic       tick
);

  // Switch synchronisers, bit order {hazard, left, right}.
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic       l_s, r_s, h_s, haz;

  tb_state_t  state_q, state_d;
  logic [5:0] leds_q, leds_d;

  tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-stage shift toward the synchronised copies.
  always_comb begin
    sync1_d = {hazard, left, right};
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign h_s = sync2_q[2];
  assign l_s = sync2_q[1];
  assign r_s = sync2_q[0];
  // Both turn switches at once behaves exactly like hazard.
  assign haz = h_s | (l_s & r_s);

  // Next-state decode; only advances on a step tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (haz)      state_d = ST_LR3;
          else if (l_s) state_d = ST_L1;
          else if (r_s) state_d = ST_R1;
          else          state_d = ST_IDLE;
        end
        ST_L1:   state_d = haz ? ST_LR3 : ST_L2;
        ST_L2:   state_d = haz ? ST_LR3 : ST_L3;
        ST_L3:   state_d = ST_IDLE;
        ST_R1:   state_d = haz ? ST_LR3 : ST_R2;
        ST_R2:   state_d = haz ? ST_LR3 : ST_R3;
        ST_R3:   state_d = ST_IDLE;
        ST_LR3:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Lamps follow the next state so they change on the same edge.
    leds_d = led_pattern(state_d);
  end

  // State and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      leds_q  <= LED_IDLE;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
    end
  end

  assign LEDS = leds_q;

endmodule
